// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a single-port byte memory with a 1-cycle
// registered read. Serves one single-byte transaction at a time. When both
// ports request together, the port not served last wins (round-robin).
// Port 0 is the cpu; port 1 is the loader/debug master.
//
// Every output is registered. A transaction's completion is presented in the
// IDLE cycle that follows its last working state. The done pulse, read data
// and (for writes) the mem_write strobe all appear together in that cycle.
// Counted from the IDLE cycle in which the grant is made, a read completes
// 3 cycles later and a write 2 cycles later.
//
// Ports
//   clk            in   single clock, rising edge
//   reset          in   asynchronous, active-low reset
//   req0/req1      in   request pending (held until done)
//   we0/we1        in   1 = write, 0 = read
//   addr0/addr1    in   byte address [addr_width-1:0]
//   wdata0/wdata1  in   write byte
//   done0/done1    out  one-cycle completion pulse
//   rdata0/rdata1  out  read byte, holds between reads of that port
//   mem_raddr      out  memory read address
//   mem_waddr      out  memory write address
//   mem_data_in    out  byte written to memory
//   mem_write      out  one-cycle memory write strobe
//   mem_data_out   in   byte read from memory (valid one cycle after raddr)
//   busy           out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [addr_width-1:0] addr0,
    input  logic [7:0]            wdata0,
    output logic                  done0,
    output logic [7:0]            rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [addr_width-1:0] addr1,
    input  logic [7:0]            wdata1,
    output logic                  done1,
    output logic [7:0]            rdata1,

    output logic [addr_width-1:0] mem_raddr,
    output logic [addr_width-1:0] mem_waddr,
    output logic [7:0]            mem_data_in,
    output logic                  mem_write,
    input  logic [7:0]            mem_data_out,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic                  gnt;        // port owning the current transaction
    logic                  last;       // port granted most recently
    logic                  grant_en;
    logic                  grant_sel;
    logic                  sel_we;
    logic [addr_width-1:0] sel_addr;
    logic [7:0]            sel_wdata;

    // While a done pulse is still showing, the finished requester has not yet
    // had a chance to drop its req. Granting in that cycle would serve the
    // same request twice, so the grant waits one IDLE cycle.
    assign grant_en  = (state == IDLE) && !(done0 || done1) && (req0 || req1);
    assign grant_sel = (req0 && req1) ? ~last : req1;

    assign sel_we    = grant_sel ? we1    : we0;
    assign sel_addr  = grant_sel ? addr1  : addr0;
    assign sel_wdata = grant_sel ? wdata1 : wdata0;

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: defaults are assigned before the case so no path leaves
    // state_next unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_en) state_next = sel_we ? WR : RD_WAIT;
            RD_WAIT: state_next = RD_DATA;
            RD_DATA: state_next = IDLE;
            WR:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered datapath and strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt         <= 1'b0;
            last        <= 1'b1;    // port 0 wins the first tie
            mem_raddr   <= '0;
            mem_waddr   <= '0;
            mem_data_in <= 8'h00;
            mem_write   <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            rdata0      <= 8'h00;
            rdata1      <= 8'h00;
        end else begin
            // Strobes are single-cycle: cleared unless re-armed below.
            done0     <= 1'b0;
            done1     <= 1'b0;
            mem_write <= 1'b0;

            // Request inputs are sampled only here; afterwards the
            // requester's req may fall without affecting the transaction.
            if (grant_en) begin
                gnt  <= grant_sel;
                last <= grant_sel;
                if (sel_we) begin
                    mem_waddr   <= sel_addr;
                    mem_data_in <= sel_wdata;
                end else begin
                    mem_raddr   <= sel_addr;
                end
            end

            case (state)
                RD_DATA: begin
                    if (gnt) begin
                        rdata1 <= mem_data_out;
                        done1  <= 1'b1;
                    end else begin
                        rdata0 <= mem_data_out;
                        done0  <= 1'b1;
                    end
                end
                WR: begin
                    mem_write <= 1'b1;
                    if (gnt) done1 <= 1'b1;
                    else     done0 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
